// File: rtl/piso_pkg.sv
// Shared types and constants for the PISO serializer.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_e;

  localparam int PISO_N_DEFAULT = 4;

endpackage

// File: rtl/piso_hold_buf.sv
// One-entry word buffer (valid/data) used to chain frames back to back.
module piso_hold_buf
  import piso_pkg::*;
#(
  parameter int N = PISO_N_DEFAULT
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load,
  input  logic [N-1:0] load_data,
  input  logic         pop,
  output logic         valid,
  output logic [N-1:0] data
);

  logic         valid_q, valid_d;
  logic [N-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end else if (pop) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer, LSB first, with downstream stall.
// Define PISO_HOLD_BUF_EN to add a one-entry buffer for gap-free back-to-back frames.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int N = PISO_N_DEFAULT
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         in_valid,
  input  logic [N-1:0] in_data,
  output logic         in_ready,
  input  logic         out_hold,
  output logic         ser_out,
  output logic         ser_en,
  output logic         frame_done,
  output logic         busy
);

  localparam int            CW       = $clog2(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  piso_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  sreg_q, sreg_d;
  logic          hs, shift_en, last_edge;

  assign shift_en  = (state_q == SHIFT) && !out_hold;
  assign last_edge = shift_en && (cnt_q == CNT_LAST);
  assign hs        = in_valid && in_ready;

`ifdef PISO_HOLD_BUF_EN
  logic         hold_valid;
  logic [N-1:0] hold_data;
  logic         buf_load, buf_pop;

  // in_ready is forced low while reset is asserted, not just after the next edge.
  assign in_ready = reset_n && !hold_valid;
  assign buf_pop  = last_edge && hold_valid;
  // A handshake on the last-bit edge with an empty buffer goes straight to sreg.
  assign buf_load = hs && (state_q == SHIFT) && !(last_edge && !hold_valid);

  piso_hold_buf #(.N(N)) u_hold_buf (
    .clock     (clock),
    .reset_n   (reset_n),
    .load      (buf_load),
    .load_data (in_data),
    .pop       (buf_pop),
    .valid     (hold_valid),
    .data      (hold_data)
  );
`else
  assign in_ready = reset_n && (state_q == IDLE);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sreg_d  = sreg_q;
    case (state_q)
      IDLE: begin
        if (hs) begin
          sreg_d  = in_data;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (last_edge) begin
          cnt_d   = '0;
          sreg_d  = '0;
          state_d = IDLE;
`ifdef PISO_HOLD_BUF_EN
          if (hold_valid) begin
            sreg_d  = hold_data;
            state_d = SHIFT;
          end else if (hs) begin
            sreg_d  = in_data;
            state_d = SHIFT;
          end
`endif
        end else if (shift_en) begin
          sreg_d = sreg_q >> 1;
          cnt_d  = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sreg_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sreg_q  <= sreg_d;
    end
  end

  assign ser_en     = shift_en;
  assign ser_out    = shift_en && sreg_q[0];
  assign frame_done = last_edge;
  assign busy       = (state_q == SHIFT);

endmodule
